// File: rtl/id_alu_decode_if.sv
// Decode-to-execute bundle: decode-stage inputs and the registered E-stage control word.
interface id_alu_decode_if;
    logic [31:0] dinst;
    logic [63:0] dpc;
    logic        dvalid;
    logic        stall;
    logic        flush;
    logic        evalid;
    logic [63:0] epc;
    logic [3:0]  ealuc;
    logic [63:0] eimm;
    logic        easel;
    logic        ebsel;
    logic [1:0]  eshmask;
    logic        eillegal;

    // Upstream side: supplies the instruction and pipeline control, observes the E slot.
    modport master (
        output dinst, dpc, dvalid, stall, flush,
        input  evalid, epc, ealuc, eimm, easel, ebsel, eshmask, eillegal
    );

    // Decode stage itself.
    modport slave (
        input  dinst, dpc, dvalid, stall, flush,
        output evalid, epc, ealuc, eimm, easel, ebsel, eshmask, eillegal
    );
endinterface

// File: rtl/id_alu_decode.sv
// RV64 decode stage: turns dinst into the registered ALU control word for execute.
module id_alu_decode (
    input logic           clk,
    input logic           rst,
    id_alu_decode_if.slave bus
);

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcOpImmW = 7'b0011011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcOpW    = 7'b0111011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [3:0] AluAdd = 4'h0, AluSub = 4'h1, AluAnd = 4'h2, AluOr = 4'h3;
    localparam logic [3:0] AluXor = 4'h4, AluSll = 4'h5, AluSrl = 4'h6, AluSra = 4'h7;
    localparam logic [3:0] AluAddw = 4'h8, AluSubw = 4'h9, AluPassA = 4'hA, AluPassB = 4'hB;
    localparam logic [3:0] AluSllw = 4'hD, AluSrlw = 4'hE, AluSraw = 4'hF;

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  aluc_c;
    logic [63:0] imm_c;
    logic        asel_c, bsel_c, ill_c;
    logic [1:0]  shm_c;

    logic        evalid_q, easel_q, ebsel_q, eillegal_q;
    logic [63:0] epc_q, eimm_q;
    logic [3:0]  ealuc_q;
    logic [1:0]  eshmask_q;

    assign inst  = bus.dinst;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Combinational decode; anything not matched falls through to illegal.
    always_comb begin
        aluc_c = AluAdd;
        imm_c  = '0;
        asel_c = 1'b0;
        bsel_c = 1'b0;
        shm_c  = 2'b00;
        ill_c  = 1'b0;
        unique case (opc)
            OpcOp: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  aluc_c = AluAdd;
                        3'b001:  begin aluc_c = AluSll; shm_c = 2'b01; end
                        3'b100:  aluc_c = AluXor;
                        3'b101:  begin aluc_c = AluSrl; shm_c = 2'b01; end
                        3'b110:  aluc_c = AluOr;
                        3'b111:  aluc_c = AluAnd;
                        default: ill_c = 1'b1;  // slt/sltu: no compare op in the ALU
                    endcase
                end else if (f7 == 7'h20) begin
                    case (f3)
                        3'b000:  aluc_c = AluSub;
                        3'b101:  begin aluc_c = AluSra; shm_c = 2'b01; end
                        default: ill_c = 1'b1;
                    endcase
                end else begin
                    ill_c = 1'b1;
                end
            end
            OpcOpImm: begin
                bsel_c = 1'b1;
                imm_c  = imm_i;
                case (f3)
                    3'b000: aluc_c = AluAdd;
                    3'b100: aluc_c = AluXor;
                    3'b110: aluc_c = AluOr;
                    3'b111: aluc_c = AluAnd;
                    3'b001: begin
                        aluc_c = AluSll;
                        ill_c  = (inst[31:26] != 6'b000000);
                    end
                    3'b101: begin
                        if (inst[31:26] == 6'b000000)      aluc_c = AluSrl;
                        else if (inst[31:26] == 6'b010000) aluc_c = AluSra;
                        else                               ill_c  = 1'b1;
                    end
                    default: ill_c = 1'b1;
                endcase
                // Shifts carry only the shamt so the funct bits never reach the ALU.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm_c = {58'b0, inst[25:20]};
                    shm_c = 2'b01;
                end
            end
            OpcOpW: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  aluc_c = AluAddw;
                        3'b001:  begin aluc_c = AluSllw; shm_c = 2'b10; end
                        3'b101:  begin aluc_c = AluSrlw; shm_c = 2'b10; end
                        default: ill_c = 1'b1;
                    endcase
                end else if (f7 == 7'h20) begin
                    case (f3)
                        3'b000:  aluc_c = AluSubw;
                        3'b101:  begin aluc_c = AluSraw; shm_c = 2'b10; end
                        default: ill_c = 1'b1;
                    endcase
                end else begin
                    ill_c = 1'b1;
                end
            end
            OpcOpImmW: begin
                bsel_c = 1'b1;
                imm_c  = imm_i;
                case (f3)
                    3'b000: aluc_c = AluAddw;
                    3'b001: begin
                        aluc_c = AluSllw;
                        ill_c  = (f7 != 7'b0000000);
                    end
                    3'b101: begin
                        if (f7 == 7'b0000000)      aluc_c = AluSraw - 4'h1;
                        else if (f7 == 7'b0100000) aluc_c = AluSraw;
                        else                       ill_c  = 1'b1;
                    end
                    default: ill_c = 1'b1;
                endcase
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm_c = {59'b0, inst[24:20]};
                    shm_c = 2'b10;
                end
            end
            OpcLui:   begin aluc_c = AluPassB; imm_c = imm_u; bsel_c = 1'b1; end
            OpcAuipc: begin aluc_c = AluAdd; imm_c = imm_u; asel_c = 1'b1; bsel_c = 1'b1; end
            OpcLoad:  begin aluc_c = AluAdd; imm_c = imm_i; bsel_c = 1'b1; end
            OpcStore: begin aluc_c = AluAdd; imm_c = imm_s; bsel_c = 1'b1; end
            OpcBranch:              begin aluc_c = AluPassA; imm_c = imm_b; end
            OpcJal:                 begin aluc_c = AluPassA; imm_c = imm_j; end
            OpcJalr:                begin aluc_c = AluPassA; imm_c = imm_i; end
            OpcFence, OpcSystem:    aluc_c = AluPassA;
            default:                ill_c = 1'b1;
        endcase
        // Illegal slot presents a fixed, harmless control word.
        if (ill_c) begin
            aluc_c = AluPassA;
            imm_c  = '0;
            asel_c = 1'b0;
            bsel_c = 1'b0;
            shm_c  = 2'b00;
        end
    end

    // E-stage register: rst > flush > stall > load (bubble when dvalid is low).
    always_ff @(posedge clk) begin
        if (rst || bus.flush || (!bus.stall && !bus.dvalid)) begin
            evalid_q   <= 1'b0;
            epc_q      <= '0;
            ealuc_q    <= AluAdd;
            eimm_q     <= '0;
            easel_q    <= 1'b0;
            ebsel_q    <= 1'b0;
            eshmask_q  <= 2'b00;
            eillegal_q <= 1'b0;
        end else if (!bus.stall) begin
            evalid_q   <= 1'b1;
            epc_q      <= bus.dpc;
            ealuc_q    <= aluc_c;
            eimm_q     <= imm_c;
            easel_q    <= asel_c;
            ebsel_q    <= bsel_c;
            eshmask_q  <= shm_c;
            eillegal_q <= ill_c;
        end
    end

    assign bus.evalid   = evalid_q;
    assign bus.epc      = epc_q;
    assign bus.ealuc    = ealuc_q;
    assign bus.eimm     = eimm_q;
    assign bus.easel    = easel_q;
    assign bus.ebsel    = ebsel_q;
    assign bus.eshmask  = eshmask_q;
    assign bus.eillegal = eillegal_q;

endmodule
